// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per cycle, MSB first, saturating on overflow.
// Optional feature: define BCD_DIGIT_CHECK_EN to flag (and zero) words containing a digit above 9.
module bcd_to_binary_seq #(
  parameter int N_DIGITS = 7,
  parameter int OUT_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] digits_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      result,
  output logic                  ovf,
  output logic                  err
);

  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int EXT_W = OUT_W + 4;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [OUT_W-1:0]      result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;

  logic [3:0]            digit;
  logic [EXT_W-1:0]      acc_ext;
  logic [EXT_W-1:0]      mac;
  logic                  mac_ovf;
  logic                  bad_digit;

  // Select the current digit and form acc*10 + digit with shifts; the 4 spare bits expose overflow.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) digit = digits_q[4*i +: 4];
    end
    acc_ext = {4'b0000, acc_q};
    mac     = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit};
    mac_ovf = (mac[EXT_W-1:OUT_W] != 4'd0);
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = digits_in;
          acc_d    = '0;
          ovf_d    = 1'b0;
          err_d    = bad_digit;
          cnt_d    = CNT_W'(N_DIGITS - 1);
          state_d  = CONV;
        end
      end
      CONV: begin
        // An erroneous word keeps acc at zero so it reports result 0 with ovf 0.
        if (!err_q) begin
          if (ovf_q || mac_ovf) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = mac[OUT_W-1:0];
          end
        end
        if (cnt_q == '0) begin
          result_d = acc_d;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq: default 7x24 instance plus 7x23 and 1x4 instances.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, ovf, err;
  logic [27:0] digits_in;
  logic [23:0] result;

  logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_ovf, o_err;
  logic [27:0] o_digits_in;
  logic [22:0] o_result;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf, s_err;
  logic [3:0]  s_digits_in;
  logic [3:0]  s_result;

  int errors = 0;
  int checks = 0;

  bcd_to_binary_seq #(.N_DIGITS(7), .OUT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .digits_in(digits_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .err(err)
  );

  bcd_to_binary_seq #(.N_DIGITS(7), .OUT_W(23)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .digits_in(o_digits_in), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .result(o_result), .ovf(o_ovf), .err(o_err)
  );

  bcd_to_binary_seq #(.N_DIGITS(1), .OUT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .digits_in(s_digits_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .ovf(s_ovf), .err(s_err)
  );

  // Waits for out_valid on the default instance, counting edges; gives up after 40.
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic accept_word(input logic [27:0] w);
    digits_in = w;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 24'd0) begin errors++; $display("[TB] FAIL reset_result: got %0d want 0", result); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got ovf=%b err=%b want 0 0", ovf, err); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_basic;
    int cyc;
    accept_word(28'h1234567);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got in_ready=%b want 0", in_ready); end
    wait_out(cyc);
    checks++; if (cyc != 7) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 7", cyc); end
    checks++; if (result !== 24'h12D687) begin errors++; $display("[TB] FAIL basic_result: got %h want 12d687", result); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL basic_flags: got ovf=%b err=%b want 0 0", ovf, err); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_bad_digit;
    int cyc;
    logic [23:0] exp_res;
    logic        exp_err;
`ifdef BCD_DIGIT_CHECK_EN
    exp_res = 24'd0;
    exp_err = 1'b1;
`else
    exp_res = 24'd20;
    exp_err = 1'b0;
`endif
    accept_word(28'h000001A);
    wait_out(cyc);
    checks++; if (cyc != 7) begin errors++; $display("[TB] FAIL bad_digit_latency: got %0d want 7", cyc); end
    checks++; if (result !== exp_res) begin errors++; $display("[TB] FAIL bad_digit_result: got %0d want %0d", result, exp_res); end
    checks++; if (err !== exp_err || ovf !== 1'b0) begin errors++; $display("[TB] FAIL bad_digit_flags: got err=%b ovf=%b want %b 0", err, ovf, exp_err); end
    consume();
  endtask

  task automatic test_backpressure;
    int cyc;
    accept_word(28'h0000042);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i % 2 == 0);
      digits_in = 28'h7777777;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_handshake[%0d]: got out_valid=%b in_ready=%b want 1 0", i, out_valid, in_ready); end
      checks++; if (result !== 24'd42 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL hold_result[%0d]: got %0d ovf=%b want 42 0", i, result, ovf); end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL no_same_cycle_accept: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit seen;
    accept_word(28'h1234567);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    checks++; if (result !== 24'd0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_result: got %0d ovf=%b want 0 0", result, ovf); end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL abandoned_word: got out_valid=1 want never"); end
    accept_word(28'h7654321);
    wait_out(cyc);
    checks++; if (cyc != 7 || result !== 24'd7654321) begin errors++; $display("[TB] FAIL after_reset_word: got %0d in %0d cycles want 7654321 in 7", result, cyc); end
    consume();
  endtask

  task automatic test_overflow;
    int cyc;
    o_digits_in = 28'h9999999;
    o_in_valid  = 1'b1;
    @(posedge clk); #1;
    o_in_valid  = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!o_out_valid && cyc < 40);
    checks++; if (cyc != 7) begin errors++; $display("[TB] FAIL ovf_latency: got %0d want 7", cyc); end
    checks++; if (o_result !== 23'h7FFFFF) begin errors++; $display("[TB] FAIL ovf_result: got %h want 7fffff", o_result); end
    checks++; if (o_ovf !== 1'b1 || o_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_flags: got ovf=%b err=%b want 1 0", o_ovf, o_err); end
    o_out_ready = 1'b1;
    @(posedge clk); #1;
    o_out_ready = 1'b0;
  endtask

  task automatic test_single_digit;
    int cyc;
    s_digits_in = 4'h7;
    s_in_valid  = 1'b1;
    @(posedge clk); #1;
    s_in_valid  = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!s_out_valid && cyc < 40);
    checks++; if (cyc != 1 || s_result !== 4'd7) begin errors++; $display("[TB] FAIL single_digit: got %0d in %0d cycles want 7 in 1", s_result, cyc); end
    checks++; if (s_ovf !== 1'b0 || s_err !== 1'b0) begin errors++; $display("[TB] FAIL single_flags: got ovf=%b err=%b want 0 0", s_ovf, s_err); end
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [27:0] words [2];
    logic [23:0] exp   [2];
    logic [23:0] got;
    int low, guard;
    bit seen;
    words[0] = 28'h0000000; exp[0] = 24'd0;
    words[1] = 28'h9999999; exp[1] = 24'd9999999;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      digits_in = words[w];
      in_valid  = 1'b1;
      @(posedge clk); #1;
      if (w == 1) in_valid = 1'b0;
      else digits_in = words[1];
      low = 0; guard = 0; seen = 1'b0; got = '1;
      while (!in_ready && guard < 40) begin
        low++;
        if (out_valid) begin seen = 1'b1; got = result; end
        @(posedge clk); #1;
        guard++;
      end
      checks++; if (low != 8) begin errors++; $display("[TB] FAIL b2b_busy[%0d]: got %0d cycles want 8", w, low); end
      checks++; if (!seen || got !== exp[w]) begin errors++; $display("[TB] FAIL b2b_result[%0d]: got %0d seen=%b want %0d", w, got, seen, exp[w]); end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; digits_in = '0;
    o_in_valid = 1'b0; o_out_ready = 1'b0; o_digits_in = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_digits_in = '0;
    test_reset();
    test_basic();
    test_bad_digit();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_single_digit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
